// File: rtl/register_file_reader_16_bit.sv
// Eight-entry, 16-bit register file with two bypassed combinational read ports,
// one clocked write port and a bit-serial (MSB first, reg0 first) dump engine.
module register_file_reader_16_bit #(
   parameter int NREG = 8,
   parameter int AW   = 3,
   parameter int W    = 16
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr_a,
   output logic [W-1:0]  rdata_a,
   input  logic [AW-1:0] raddr_b,
   output logic [W-1:0]  rdata_b,
   input  logic          dump_start,
   output logic          dump_busy,
   output logic          dump_done,
   output logic          ser_valid,
   output logic          ser_data,
   input  logic          ser_ready
);
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  shift_q, shift_d;
   logic [W-1:0]  regs_q [NREG];
   logic [W-1:0]  load_val;
   logic          last_bit;

   // NOTE: the register array is cleared by the asynchronous reset, so it has to
   // stay as individual flops; a RAM macro could not honour that clear.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (we) begin
         regs_q[waddr] <= wdata;
      end
   end

   // A write in the same cycle is forwarded, both to the ALU ports and to LOAD.
   assign rdata_a  = (we && waddr == raddr_a) ? wdata : regs_q[raddr_a];
   assign rdata_b  = (we && waddr == raddr_b) ? wdata : regs_q[raddr_b];
   assign load_val = (we && waddr == idx_q)   ? wdata : regs_q[idx_q];
   assign last_bit = (cnt_q == CW'(W - 1));

   // NOTE: every variable gets a default before the case so no path can leave
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      dump_busy = 1'b1;
      dump_done = 1'b0;
      ser_valid = 1'b0;
      ser_data  = 1'b0;
      case (state_q)
         IDLE: begin
            dump_busy = 1'b0;
            if (dump_start) begin
               idx_d   = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            shift_d = load_val;
            cnt_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            ser_valid = 1'b1;
            ser_data  = shift_q[W-1];
            if (ser_ready) begin
               shift_d = {shift_q[W-2:0], 1'b0};
               cnt_d   = cnt_q + CW'(1);
               if (last_bit) begin
                  if (idx_q == AW'(NREG - 1)) begin
                     state_d = DONE;
                  end else begin
                     idx_d   = idx_q + AW'(1);
                     state_d = LOAD;
                  end
               end
            end
         end
         DONE: begin
            dump_done = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // the values from before the edge.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
      end
   end

endmodule

// File: doc/register_file_reader_16_bit.md
# register_file_reader_16_bit

Eight-entry, 16-bit general-purpose register file for the single-cycle RISC datapath. It has two combinational read ports for the ALU operands and one clocked write port from write-back. A built-in debug dump engine walks every register and streams its contents out over a bit-serial valid/ready link. The dump engine is the read-out end for values the datapath writes: it lets the bench or a debug host see full architectural state without stopping the core.

## Interface
- NREG, 8, number of registers (power of two)
- AW, 3, register address width, log2(NREG)
- W, 16, register data width

- clk  input  1  rising-edge clock
- clr  input  1  asynchronous, active-low reset (0 = reset)
- we  input  1  write enable for the write port
- waddr  input  AW  write address
- wdata  input  W  write data
- raddr_a  input  AW  read port A address
- rdata_a  output  W  read port A data (combinational)
- raddr_b  input  AW  read port B address
- rdata_b  output  W  read port B data (combinational)
- dump_start  input  1  single-cycle request to begin a dump
- dump_busy  output  1  dump in progress
- dump_done  output  1  one-cycle pulse when the dump completes
- ser_valid  output  1  ser_data holds a valid bit
- ser_data  output  1  serial dump bit
- ser_ready  input  1  sink accepts the bit this cycle

## Operation
- Reset (clr=0, asynchronous):
  - all registers go to 0
  - FSM goes to IDLE
  - dump_busy, dump_done, ser_valid and ser_data go to 0
  - register index and bit counter go to 0
- Write: when we=1 at a rising edge, reg[waddr] <= wdata. All registers, including r0, are writable.
- Read: rdata_x = reg[raddr_x], with write bypass. If we=1 and raddr_x==waddr, rdata_x = wdata in the same cycle.
- Dump FSM states and transitions:
  - IDLE: dump_start=1 -> LOAD, with idx=0. dump_start is ignored in every other state.
  - LOAD: shift register <= bypassed value of reg[idx], bit counter <= 0 -> SHIFT.
  - SHIFT: ser_valid=1 and ser_data=shift[W-1] (MSB first). On ser_valid&&ser_ready, shift left by 1 and increment the bit counter. When the handshake on bit W-1 completes:
    - idx==NREG-1 -> DONE
    - otherwise idx++ -> LOAD
  - DONE: dump_done=1 for exactly one cycle -> IDLE.
- dump_busy=1 in LOAD, SHIFT and DONE; 0 in IDLE.
- ser_valid=0 outside SHIFT, and ser_data=0 outside SHIFT.
- Snapshot rule: each register is sampled at its own LOAD. A write to reg[k] becomes visible in the stream only if it lands at or before LOAD of k.
- Once ser_valid is high, ser_data is held stable until the handshake. There is no abort; only reset stops a dump.
- Stream order: reg0 bit15..bit0, then reg1, and so on up to reg[NREG-1]. The stream is NREG*W = 128 bits.

## Timing
- Write latency: 1 edge. Read is combinational, so there is zero latency via bypass.
- With dump_start sampled at edge N and ser_ready held at 1:
  - LOAD occupies cycle N+1
  - the first bit is valid in cycle N+2
  - each register takes 1 LOAD cycle + 16 SHIFT cycles = 17 cycles
  - DONE (dump_done=1) occurs in cycle N+137
  - IDLE resumes at N+138
- ser_ready=0 stalls SHIFT indefinitely with ser_data held. Each idle cycle adds exactly one cycle of latency.
- dump_start asserted in DONE is ignored. A new dump can start from IDLE on the following cycle.
- Reset asserted mid-dump:
  - outputs drop immediately, without waiting for a clock
  - registers clear
  - after release, the FSM waits in IDLE for dump_start

## Test plan
- Reset, then write reg[i]=16'h1111*i for i=0..7, then read both ports over all addresses -> rdata matches; reg0=0000, reg7=7777.
- Bypass: hold we=1, waddr=3, wdata=ABCD with raddr_a=3 before the edge -> rdata_a=ABCD in that same cycle.
- Dump with ser_ready=1 and the registers from test 1:
  - collected 128 bits equal 0000,1111,...,7777 MSB first
  - dump_done pulses in cycle N+137
  - dump_busy is high for exactly 137 cycles
- Backpressure: toggle ser_ready pseudo-randomly -> the stream is identical to the previous test, ser_data never changes while ser_valid&&!ser_ready, and the done cycle shifts by the number of stall cycles.
- Concurrent write during dump:
  - write reg5=DEAD while streaming reg2 -> stream shows DEAD for reg5
  - write reg1=BEEF during reg3 -> stream shows the old reg1 value
- Reset mid-dump: assert clr=0 during reg4 bit 7 -> ser_valid, dump_busy and all registers read 0 immediately, and the FSM restarts only on a new dump_start.
